// File: rtl/dispatch_ctrl_if.sv
// dispatch_ctrl_if: bundles the decode-side and issue-side handshakes of dispatch_ctrl.
//
// Signals:
//   dec_valid    decode -> ctrl   decoded uop offered
//   dec_ready    ctrl -> decode   FIFO can accept
//   dec_uop      decode -> ctrl   opaque uop payload
//   dec_iq_type  decode -> ctrl   target queue: 0=INT, 1=MEM, 2=FP, 3=illegal
//   dec_is_br    decode -> ctrl   uop allocates a branch tag
//   iq_valid     ctrl -> queues   one-hot dispatch strobe, bit index = queue type
//   iq_ready     queues -> ctrl   per-queue accept
//   iq_uop       ctrl -> queues   head payload
//   iq_br_tag    ctrl -> queues   branch tag attached to the head uop
//
// Modports: master = decode/issue-queue side, slave = dispatch_ctrl.
interface dispatch_ctrl_if #(
    parameter int unsigned UOP_W = 64,
    parameter int unsigned TAG_W = 2
);
    logic             dec_valid;
    logic             dec_ready;
    logic [UOP_W-1:0] dec_uop;
    logic [1:0]       dec_iq_type;
    logic             dec_is_br;
    logic [2:0]       iq_valid;
    logic [2:0]       iq_ready;
    logic [UOP_W-1:0] iq_uop;
    logic [TAG_W-1:0] iq_br_tag;

    modport master (
        output dec_valid, dec_uop, dec_iq_type, dec_is_br, iq_ready,
        input  dec_ready, iq_valid, iq_uop, iq_br_tag
    );

    modport slave (
        input  dec_valid, dec_uop, dec_iq_type, dec_is_br, iq_ready,
        output dec_ready, iq_valid, iq_uop, iq_br_tag
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: buffers decoded uops in a small in-order FIFO and routes the head entry to
// the INT, MEM or FP issue queue selected by its type. Branch dispatch is throttled against a
// bounded count of unresolved branches, and every dispatched uop carries a branch tag.
// A flush discards all buffered entries and branch bookkeeping.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          synchronous reset, active-high
//   bus          decode/issue handshakes (dispatch_ctrl_if.slave)
//   br_resolve   oldest unresolved branch resolved (in order)
//   flush        discard everything buffered; highest priority after rst
//   br_inflight  number of unresolved dispatched branches
//   fifo_count   FIFO occupancy
//   err_illegal  one-cycle pulse after an illegal-type head entry is dropped
//
// DEPTH and MAX_BR must be powers of two; TAG_W must equal log2(MAX_BR).
module dispatch_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned UOP_W  = 64,
    parameter int unsigned MAX_BR = 4,
    parameter int unsigned TAG_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    dispatch_ctrl_if.slave            bus,
    input  logic                      br_resolve,
    input  logic                      flush,
    output logic [$clog2(MAX_BR):0]   br_inflight,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      err_illegal
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BR_W  = $clog2(MAX_BR) + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [BR_W-1:0]  BR_FULL  = BR_W'(MAX_BR);
    localparam logic [BR_W-1:0]  BR_ONE   = BR_W'(1);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

    localparam logic [1:0] TYPE_ILLEGAL = 2'd3;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [UOP_W-1:0] uop_mem  [DEPTH];
    logic [1:0]       type_mem [DEPTH];
    logic [DEPTH-1:0] br_mem;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BR_W-1:0]  inflight_q, inflight_d;
    logic [TAG_W-1:0] tag_ptr_q, tag_ptr_d;
    logic             err_q, err_d;

    // ------------------------------------------------------------------
    // Head decode and handshakes
    // ------------------------------------------------------------------
    logic       dec_ready;
    logic       enq;
    logic       head_valid;
    logic [1:0] head_type;
    logic       head_br;
    logic       head_legal;
    logic       br_stall;
    logic [2:0] iq_valid;
    logic       dispatch;
    logic       drop_illegal;
    logic       deq;
    logic       br_dispatch;
    logic       resolve_ok;

    // Ready depends only on registered occupancy, never on the issue side.
    assign dec_ready  = (count_q != CNT_FULL);
    assign enq        = bus.dec_valid & dec_ready & ~flush;

    assign head_valid = (count_q != '0);
    assign head_type  = type_mem[rd_ptr_q];
    assign head_br    = br_mem[rd_ptr_q];
    assign head_legal = (head_type != TYPE_ILLEGAL);

    // A branch at the head waits while every tag is still unresolved.
    assign br_stall   = head_br & (inflight_q == BR_FULL);

    always_comb begin
        iq_valid = 3'b000;
        if (head_valid && head_legal && !br_stall && !flush) begin
            unique case (head_type)
                2'd0:    iq_valid = 3'b001;
                2'd1:    iq_valid = 3'b010;
                2'd2:    iq_valid = 3'b100;
                default: iq_valid = 3'b000;
            endcase
        end
    end

    assign dispatch     = |(iq_valid & bus.iq_ready);
    // Illegal entries leave the FIFO silently so they cannot block younger uops.
    assign drop_illegal = head_valid & ~head_legal & ~flush;
    assign deq          = dispatch | drop_illegal;
    assign br_dispatch  = dispatch & head_br;
    // Resolve with nothing outstanding is ignored to avoid underflow.
    assign resolve_ok   = br_resolve & (inflight_q != '0) & ~flush;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        tag_ptr_d  = tag_ptr_q;
        err_d      = drop_illegal;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            inflight_d = '0;
            tag_ptr_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            unique case ({enq, deq})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            // A branch issue and a resolve in the same cycle cancel out.
            unique case ({br_dispatch, resolve_ok})
                2'b10:   inflight_d = inflight_q + BR_ONE;
                2'b01:   inflight_d = inflight_q - BR_ONE;
                default: inflight_d = inflight_q;
            endcase

            if (br_dispatch) begin
                tag_ptr_d = tag_ptr_q + TAG_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            tag_ptr_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            tag_ptr_q  <= tag_ptr_d;
            err_q      <= err_d;
        end
    end

    // Payload storage needs no reset: occupancy gates every use of it.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            uop_mem[wr_ptr_q]  <= bus.dec_uop;
            type_mem[wr_ptr_q] <= bus.dec_iq_type;
            br_mem[wr_ptr_q]   <= bus.dec_is_br;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.dec_ready = dec_ready;
    assign bus.iq_valid  = iq_valid;
    assign bus.iq_uop    = uop_mem[rd_ptr_q];
    // Non-branches carry the tag of the youngest older branch.
    assign bus.iq_br_tag = head_br ? tag_ptr_q : (tag_ptr_q - TAG_ONE);

    assign br_inflight   = inflight_q;
    assign fifo_count    = count_q;
    assign err_illegal   = err_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: table-driven bench for dispatch_ctrl. Each row gives the inputs driven for
// one cycle and the outputs expected in that same cycle (before the next rising edge).
module tb_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       br_resolve;
    logic       flush;
    logic [2:0] br_inflight;
    logic [2:0] fifo_count;
    logic       err_illegal;

    int n_checks = 0;
    int n_errors = 0;
    int row      = -1;

    dispatch_ctrl_if #(.UOP_W(64), .TAG_W(2)) bus ();

    dispatch_ctrl #(
        .DEPTH (4),
        .UOP_W (64),
        .MAX_BR(4),
        .TAG_W (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .br_resolve (br_resolve),
        .flush      (flush),
        .br_inflight(br_inflight),
        .fifo_count (fifo_count),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [7:0] uop;
        logic [1:0] typ;
        logic       br;
        logic [2:0] rdy;
        logic       res;
        logic       fl;
        logic       e_rdy;
        logic [2:0] e_v;
        logic [2:0] e_cnt;
        logic [2:0] e_infl;
        logic       e_err;
        logic       chk;
        logic [7:0] e_uop;
        logic [1:0] e_tag;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input int dv, input int uop, input int typ, input int br, input int rdy,
                     input int res, input int fl, input int e_rdy, input int e_v,
                     input int e_cnt, input int e_infl, input int e_err, input int chk,
                     input int e_uop, input int e_tag);
        vec_t t;
        t.dv     = 1'(dv);
        t.uop    = 8'(uop);
        t.typ    = 2'(typ);
        t.br     = 1'(br);
        t.rdy    = 3'(rdy);
        t.res    = 1'(res);
        t.fl     = 1'(fl);
        t.e_rdy  = 1'(e_rdy);
        t.e_v    = 3'(e_v);
        t.e_cnt  = 3'(e_cnt);
        t.e_infl = 3'(e_infl);
        t.e_err  = 1'(e_err);
        t.chk    = 1'(chk);
        t.e_uop  = 8'(e_uop);
        t.e_tag  = 2'(e_tag);
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.dec_valid   = t.dv;
        bus.dec_uop     = 64'(t.uop);
        bus.dec_iq_type = t.typ;
        bus.dec_is_br   = t.br;
        bus.iq_ready    = t.rdy;
        br_resolve      = t.res;
        flush           = t.fl;
    endtask

    task automatic idle_inputs();
        bus.dec_valid   = 1'b0;
        bus.dec_uop     = '0;
        bus.dec_iq_type = 2'd0;
        bus.dec_is_br   = 1'b0;
        bus.iq_ready    = 3'b000;
        br_resolve      = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Row fields: dv uop typ br rdy res fl | rdy v cnt infl err chk uop tag
        // Single INT uop, one-cycle latency
        v(1, 'hA5, 0, 0, 7, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        v(0, 0,    0, 0, 7, 0, 0,  1, 1, 1, 0, 0,  1, 'hA5, 3);
        v(0, 0,    0, 0, 7, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        // Five pushes with queues closed, then drain in order
        v(1, 'h11, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        v(1, 'h12, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0,  1, 'h11, 3);
        v(1, 'h13, 0, 0, 0, 0, 0,  1, 1, 2, 0, 0,  1, 'h11, 3);
        v(1, 'h14, 0, 0, 0, 0, 0,  1, 1, 3, 0, 0,  1, 'h11, 3);
        v(1, 'h15, 0, 0, 0, 0, 0,  0, 1, 4, 0, 0,  1, 'h11, 3);
        v(1, 'h15, 0, 0, 1, 0, 0,  0, 1, 4, 0, 0,  1, 'h11, 3);
        v(1, 'h15, 0, 0, 1, 0, 0,  1, 1, 3, 0, 0,  1, 'h12, 3);
        v(0, 0,    0, 0, 1, 0, 0,  1, 1, 3, 0, 0,  1, 'h13, 3);
        v(0, 0,    0, 0, 1, 0, 0,  1, 1, 2, 0, 0,  1, 'h14, 3);
        v(0, 0,    0, 0, 1, 0, 0,  1, 1, 1, 0, 0,  1, 'h15, 3);
        v(0, 0,    0, 0, 1, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        // Five MEM branches: tags 0..3, fifth stalls until one resolve
        v(1, 'h21, 1, 1, 2, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        v(1, 'h22, 1, 1, 2, 0, 0,  1, 2, 1, 0, 0,  1, 'h21, 0);
        v(1, 'h23, 1, 1, 2, 0, 0,  1, 2, 1, 1, 0,  1, 'h22, 1);
        v(1, 'h24, 1, 1, 2, 0, 0,  1, 2, 1, 2, 0,  1, 'h23, 2);
        v(1, 'h25, 1, 1, 2, 0, 0,  1, 2, 1, 3, 0,  1, 'h24, 3);
        v(0, 0,    0, 0, 2, 0, 0,  1, 0, 1, 4, 0,  1, 'h25, 0);
        v(0, 0,    0, 0, 2, 1, 0,  1, 0, 1, 4, 0,  1, 'h25, 0);
        v(0, 0,    0, 0, 2, 0, 0,  1, 2, 1, 3, 0,  1, 'h25, 0);
        v(0, 0,    0, 0, 2, 0, 0,  1, 0, 0, 4, 0,  0, 0, 0);
        // Resolve down to 2, branch dispatch + resolve together, then underflow guard
        v(0, 0,    0, 0, 0, 1, 0,  1, 0, 0, 4, 0,  0, 0, 0);
        v(0, 0,    0, 0, 0, 1, 0,  1, 0, 0, 3, 0,  0, 0, 0);
        v(1, 'h31, 1, 1, 2, 0, 0,  1, 0, 0, 2, 0,  0, 0, 0);
        v(0, 0,    0, 0, 2, 1, 0,  1, 2, 1, 2, 0,  1, 'h31, 1);
        v(0, 0,    0, 0, 0, 0, 0,  1, 0, 0, 2, 0,  0, 0, 0);
        v(0, 0,    0, 0, 0, 1, 0,  1, 0, 0, 2, 0,  0, 0, 0);
        v(0, 0,    0, 0, 0, 1, 0,  1, 0, 0, 1, 0,  0, 0, 0);
        v(0, 0,    0, 0, 0, 1, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        v(0, 0,    0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        // Illegal head dropped with one error pulse, then FP uop
        v(1, 'h41, 3, 0, 7, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        v(1, 'h42, 2, 0, 7, 0, 0,  1, 0, 1, 0, 0,  0, 0, 0);
        v(0, 0,    0, 0, 7, 0, 0,  1, 4, 1, 0, 1,  1, 'h42, 1);
        v(0, 0,    0, 0, 7, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        // Two branches in flight, fill to 3, flush with a concurrent push
        v(1, 'h51, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        v(1, 'h52, 0, 1, 1, 0, 0,  1, 1, 1, 0, 0,  1, 'h51, 2);
        v(0, 0,    0, 0, 1, 0, 0,  1, 1, 1, 1, 0,  1, 'h52, 3);
        v(1, 'h61, 0, 0, 0, 0, 0,  1, 0, 0, 2, 0,  0, 0, 0);
        v(1, 'h62, 0, 0, 0, 0, 0,  1, 1, 1, 2, 0,  1, 'h61, 3);
        v(1, 'h63, 0, 0, 0, 0, 0,  1, 1, 2, 2, 0,  1, 'h61, 3);
        v(1, 'h64, 0, 0, 7, 1, 1,  1, 0, 3, 2, 0,  1, 'h61, 3);
        v(1, 'h71, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0);
        v(0, 0,    0, 0, 2, 0, 0,  1, 2, 1, 0, 0,  1, 'h71, 0);
        v(0, 0,    0, 0, 0, 0, 0,  1, 0, 0, 1, 0,  0, 0, 0);

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset dec_ready", 64'(bus.dec_ready), 64'(1));
        check("reset iq_valid", 64'(bus.iq_valid), 64'(0));
        check("reset fifo_count", 64'(fifo_count), 64'(0));
        check("reset br_inflight", 64'(br_inflight), 64'(0));
        check("reset err_illegal", 64'(err_illegal), 64'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            row = i;
            drive(vecs[i]);
            #1;
            check("dec_ready", 64'(bus.dec_ready), 64'(vecs[i].e_rdy));
            check("iq_valid", 64'(bus.iq_valid), 64'(vecs[i].e_v));
            check("fifo_count", 64'(fifo_count), 64'(vecs[i].e_cnt));
            check("br_inflight", 64'(br_inflight), 64'(vecs[i].e_infl));
            check("err_illegal", 64'(err_illegal), 64'(vecs[i].e_err));
            if (vecs[i].chk) begin
                check("iq_uop", bus.iq_uop, 64'(vecs[i].e_uop));
                check("iq_br_tag", 64'(bus.iq_br_tag), 64'(vecs[i].e_tag));
            end
            tick();
        end

        // Reset mid-stream while an illegal head is being dropped: no error pulse survives,
        // and the tag pointer restarts at 0 (it was 1 before).
        row = -2;
        idle_inputs();
        bus.dec_valid   = 1'b1;
        bus.dec_uop     = 64'h81;
        bus.dec_iq_type = 2'd3;
        tick();
        idle_inputs();
        check("pre-reset fifo_count", 64'(fifo_count), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst err_illegal", 64'(err_illegal), 64'(0));
        check("midrst fifo_count", 64'(fifo_count), 64'(0));
        check("midrst br_inflight", 64'(br_inflight), 64'(0));
        check("midrst iq_valid", 64'(bus.iq_valid), 64'(0));
        bus.dec_valid   = 1'b1;
        bus.dec_uop     = 64'h91;
        bus.dec_iq_type = 2'd0;
        bus.dec_is_br   = 1'b1;
        tick();
        idle_inputs();
        bus.iq_ready = 3'b001;
        #1;
        check("midrst iq_valid br", 64'(bus.iq_valid), 64'(1));
        check("midrst iq_uop", bus.iq_uop, 64'h91);
        check("midrst iq_br_tag", 64'(bus.iq_br_tag), 64'(0));
        tick();
        check("midrst br_inflight after", 64'(br_inflight), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
